bin_to_bcd_multi: RTL and testbench

Sequential, parametrised binary-to-BCD converter for the 7-segment display path. It uses shift-and-add-3 (double dabble) and processes one input bit per clock. It adds a valid/ready input handshake, a configurable digit count, an overflow flag and a leading-zero mask for display blanking. It sits between the value source (counter or ADC logic) and the 7-segment digit multiplexer, and replaces the fixed 2-digit converter.

---
 rtl/bin_to_bcd_multi.sv | 125 ++++++++++++
 tb/tb_bin_to_bcd_multi.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_multi.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) with
// valid/ready input, overflow flag and leading-zero blanking mask.
module bin_to_bcd_multi #(
   parameter int DATA_W = 8,
   parameter int DIGITS = 2
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [DATA_W-1:0]     i_data,
   input  logic                  i_valid,
   output logic                  o_ready,
   output logic [4*DIGITS-1:0]   o_bcd,
   output logic                  o_valid,
   output logic                  o_overflow,
   output logic [DIGITS-1:0]     o_lz_mask
);

   localparam int FULL_DIGITS = (DATA_W * 3) / 10 + 1;
   localparam int ACC_W       = 4 * FULL_DIGITS;
   localparam int CNT_W       = $clog2(DATA_W + 1);
   localparam logic [DIGITS-1:0] LZ_RST = {DIGITS{1'b1}} << 1;

   typedef enum logic {IDLE, SHIFT} state_e;

   state_e               state_q, state_d;
   logic [DATA_W-1:0]    bin_q, bin_d;
   logic [ACC_W-1:0]     acc_q, acc_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [4*DIGITS-1:0]  bcd_q, bcd_d;
   logic                 ovf_q, ovf_d;
   logic [DIGITS-1:0]    lz_q, lz_d;
   logic                 valid_q, valid_d;

   logic [ACC_W-1:0]        acc_adj;
   logic [ACC_W+DATA_W-1:0] step;
   logic [ACC_W-1:0]        acc_next;
   logic                    ovf_next;
   logic [DIGITS-1:0]       lz_next;
   logic                    all_zero;

   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      bcd_d   = bcd_q;
      ovf_d   = ovf_q;
      lz_d    = lz_q;
      valid_d = 1'b0;

      acc_adj = acc_q;
      for (int unsigned n = 0; n < FULL_DIGITS; n++) begin
         if (acc_q[4*n +: 4] >= 4'd5)
            acc_adj[4*n +: 4] = acc_q[4*n +: 4] + 4'd3;
      end
      step     = {acc_adj, bin_q} << 1;
      acc_next = step[ACC_W+DATA_W-1:DATA_W];

      // Digits above DIGITS exist only to detect overflow
      ovf_next = 1'b0;
      for (int unsigned n = DIGITS; n < FULL_DIGITS; n++)
         ovf_next = ovf_next | (|acc_next[4*n +: 4]);

      // Walk from the top digit down; a digit blanks only while all above are zero
      lz_next  = '0;
      all_zero = 1'b1;
      for (int unsigned i = 1; i < DIGITS; i++) begin
         all_zero = all_zero & (acc_next[4*(DIGITS-i) +: 4] == 4'd0);
         lz_next[DIGITS-i] = all_zero;
      end

      case (state_q)
         IDLE: begin
            if (i_valid) begin
               bin_d   = i_data;
               acc_d   = '0;
               cnt_d   = CNT_W'(DATA_W);
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            acc_d = acc_next;
            bin_d = step[DATA_W-1:0];
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
               bcd_d   = acc_next[4*DIGITS-1:0];
               ovf_d   = ovf_next;
               lz_d    = lz_next;
               valid_d = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         bin_q   <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         bcd_q   <= '0;
         ovf_q   <= 1'b0;
         lz_q    <= LZ_RST;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         bcd_q   <= bcd_d;
         ovf_q   <= ovf_d;
         lz_q    <= lz_d;
         valid_q <= valid_d;
      end
   end

   assign o_ready    = (state_q == IDLE);
   assign o_bcd      = bcd_q;
   assign o_valid    = valid_q;
   assign o_overflow = ovf_q;
   assign o_lz_mask  = lz_q;

endmodule

// File: tb/tb_bin_to_bcd_multi.sv
// Directed bench for bin_to_bcd_multi: 8-bit/2-digit, 16-bit/5-digit and
// 16-bit/3-digit instances sharing one clock and reset.
module tb_bin_to_bcd_multi;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        valid8, rdy8, ov8, of8;
   logic [7:0]  data8, bcd8;
   logic [1:0]  lz8;

   logic        va, ra, oa, ofa;
   logic [15:0] da;
   logic [19:0] bcda;
   logic [4:0]  lza;

   logic        vb, rb, ob, ofb;
   logic [15:0] db;
   logic [11:0] bcdb;
   logic [2:0]  lzb;

   int n_cmp = 0;
   int n_bad = 0;

   bin_to_bcd_multi #(.DATA_W(8), .DIGITS(2)) dut8 (
      .i_clk(clk), .i_rst_n(rst_n), .i_data(data8), .i_valid(valid8),
      .o_ready(rdy8), .o_bcd(bcd8), .o_valid(ov8), .o_overflow(of8), .o_lz_mask(lz8));

   bin_to_bcd_multi #(.DATA_W(16), .DIGITS(5)) dut16a (
      .i_clk(clk), .i_rst_n(rst_n), .i_data(da), .i_valid(va),
      .o_ready(ra), .o_bcd(bcda), .o_valid(oa), .o_overflow(ofa), .o_lz_mask(lza));

   bin_to_bcd_multi #(.DATA_W(16), .DIGITS(3)) dut16b (
      .i_clk(clk), .i_rst_n(rst_n), .i_data(db), .i_valid(vb),
      .o_ready(rb), .o_bcd(bcdb), .o_valid(ob), .o_overflow(ofb), .o_lz_mask(lzb));

   // Called at a negedge with dut8 idle; returns at the negedge where o_valid is seen.
   task automatic run8(input logic [7:0] v, output int lat, output logic [7:0] bcd,
                       output logic ovf, output logic [1:0] lz, output int ready_lo);
      lat = -1; bcd = 'x; ovf = 1'bx; lz = 'x; ready_lo = 0;
      data8 = v; valid8 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      valid8 = 1'b0;
      for (int j = 0; j < 40; j++) begin
         if (ov8) begin
            lat = j; bcd = bcd8; ovf = of8; lz = lz8;
            break;
         end
         if (!rdy8) ready_lo++;
         @(negedge clk);
      end
   endtask

   task automatic run16(input bit sel, input logic [15:0] v, output int lat,
                        output logic [19:0] bcd, output logic ovf, output logic [4:0] lz);
      lat = -1; bcd = 'x; ovf = 1'bx; lz = 'x;
      if (!sel) begin da = v; va = 1'b1; end
      else begin db = v; vb = 1'b1; end
      @(posedge clk);
      @(negedge clk);
      va = 1'b0; vb = 1'b0;
      for (int j = 0; j < 40; j++) begin
         if (!sel && oa) begin
            lat = j; bcd = bcda; ovf = ofa; lz = lza;
            break;
         end
         if (sel && ob) begin
            lat = j; bcd = {8'h00, bcdb}; ovf = ofb; lz = {2'b00, lzb};
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      n_cmp++;
      if ({rdy8, bcd8, ov8, of8, lz8} !== {1'b1, 8'h00, 1'b0, 1'b0, 2'b10}) begin
         n_bad++;
         $display("FAIL reset8: got rdy=%b bcd=%h v=%b of=%b lz=%b want 1 00 0 0 10",
                  rdy8, bcd8, ov8, of8, lz8);
      end
      n_cmp++;
      if ({ra, bcda, oa, ofa, lza} !== {1'b1, 20'h00000, 1'b0, 1'b0, 5'b11110}) begin
         n_bad++;
         $display("FAIL reset16: got rdy=%b bcd=%h v=%b of=%b lz=%b want 1 00000 0 0 11110",
                  ra, bcda, oa, ofa, lza);
      end
   endtask

   task automatic test_zero;
      int lat, rl; logic [7:0] b; logic o; logic [1:0] z;
      run8(8'd0, lat, b, o, z, rl);
      n_cmp++;
      if (lat !== 8 || rl !== 8) begin
         n_bad++;
         $display("FAIL zero_timing: got lat=%0d ready_low=%0d want 8 8", lat, rl);
      end
      n_cmp++;
      if ({b, o, z} !== {8'h00, 1'b0, 2'b10} || rdy8 !== 1'b1) begin
         n_bad++;
         $display("FAIL zero_result: got bcd=%h of=%b lz=%b rdy=%b want 00 0 10 1", b, o, z, rdy8);
      end
      @(negedge clk);
      n_cmp++;
      if (ov8 !== 1'b0 || bcd8 !== 8'h00) begin
         n_bad++;
         $display("FAIL zero_pulse: got v=%b bcd=%h want 0 00", ov8, bcd8);
      end
   endtask

   task automatic test_spot;
      int lat, rl; logic [7:0] b; logic o; logic [1:0] z;
      logic [7:0] vals [3] = '{8'd7, 8'd99, 8'd255};
      logic [10:0] exp [3] = '{{8'h07, 1'b0, 2'b10}, {8'h99, 1'b0, 2'b00}, {8'h55, 1'b1, 2'b00}};
      for (int i = 0; i < 3; i++) begin
         run8(vals[i], lat, b, o, z, rl);
         n_cmp++;
         if ({b, o, z} !== exp[i] || lat !== 8) begin
            n_bad++;
            $display("FAIL spot_%0d: got bcd=%h of=%b lz=%b lat=%0d want %h lat=8",
                     vals[i], b, o, z, lat, exp[i]);
         end
      end
   endtask

   task automatic test_sweep;
      int lat, rl; logic [7:0] b; logic o; logic [1:0] z;
      logic [7:0] eb; logic eo; logic [1:0] ez;
      int m;
      for (int v = 0; v < 256; v++) begin
         m  = v % 100;
         eb = {4'(m / 10), 4'(m % 10)};
         eo = (v > 99);
         ez = (m / 10 == 0) ? 2'b10 : 2'b00;
         run8(8'(v), lat, b, o, z, rl);
         n_cmp++;
         if ({b, o, z} !== {eb, eo, ez} || lat !== 8) begin
            n_bad++;
            $display("FAIL sweep_%0d: got bcd=%h of=%b lz=%b lat=%0d want %h %b %b 8",
                     v, b, o, z, lat, eb, eo, ez);
         end
      end
   endtask

   task automatic test_back_to_back;
      int first, second;
      logic [7:0] b1, b2;
      first = -1; second = -1; b1 = 'x; b2 = 'x;
      data8 = 8'd42; valid8 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      data8 = 8'd57;
      for (int j = 0; j < 30; j++) begin
         if (ov8) begin
            if (first < 0) begin first = j; b1 = bcd8; end
            else if (second < 0) begin second = j; b2 = bcd8; end
         end
         if (j == 9) valid8 = 1'b0;
         if (j == 11) data8 = 8'd99;
         @(negedge clk);
      end
      n_cmp++;
      if (first !== 8 || b1 !== 8'h42) begin
         n_bad++;
         $display("FAIL b2b_first: got at=%0d bcd=%h want 8 42", first, b1);
      end
      n_cmp++;
      if (second !== 17 || b2 !== 8'h57) begin
         n_bad++;
         $display("FAIL b2b_second: got at=%0d bcd=%h want 17 57", second, b2);
      end
   endtask

   task automatic test_reset_mid;
      int lat, rl, seen; logic [7:0] b; logic o; logic [1:0] z;
      data8 = 8'd200; valid8 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      valid8 = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({rdy8, bcd8, ov8, of8, lz8} !== {1'b1, 8'h00, 1'b0, 1'b0, 2'b10}) begin
         n_bad++;
         $display("FAIL abort_reset: got rdy=%b bcd=%h v=%b of=%b lz=%b want 1 00 0 0 10",
                  rdy8, bcd8, ov8, of8, lz8);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int j = 0; j < 12; j++) begin
         @(negedge clk);
         if (ov8) seen++;
      end
      n_cmp++;
      if (seen !== 0) begin
         n_bad++;
         $display("FAIL abort_novalid: got %0d pulses want 0", seen);
      end
      run8(8'd13, lat, b, o, z, rl);
      n_cmp++;
      if (b !== 8'h13 || lat !== 8 || o !== 1'b0 || z !== 2'b00) begin
         n_bad++;
         $display("FAIL abort_after: got bcd=%h lat=%0d of=%b lz=%b want 13 8 0 00", b, lat, o, z);
      end
   endtask

   task automatic test_wide;
      int lat; logic [19:0] b; logic o; logic [4:0] z;
      run16(1'b0, 16'd65535, lat, b, o, z);
      n_cmp++;
      if (b !== 20'h65535 || o !== 1'b0 || lat !== 16 || z !== 5'b00000) begin
         n_bad++;
         $display("FAIL w5_65535: got bcd=%h of=%b lat=%0d lz=%b want 65535 0 16 00000", b, o, lat, z);
      end
      run16(1'b0, 16'd1000, lat, b, o, z);
      n_cmp++;
      if (b !== 20'h01000 || o !== 1'b0 || z !== 5'b10000) begin
         n_bad++;
         $display("FAIL w5_1000: got bcd=%h of=%b lz=%b want 01000 0 10000", b, o, z);
      end
      run16(1'b0, 16'd0, lat, b, o, z);
      n_cmp++;
      if (b !== 20'h00000 || z !== 5'b11110) begin
         n_bad++;
         $display("FAIL w5_zero: got bcd=%h lz=%b want 00000 11110", b, z);
      end
      run16(1'b1, 16'd12345, lat, b, o, z);
      n_cmp++;
      if (b[11:0] !== 12'h345 || o !== 1'b1 || lat !== 16 || z[2:0] !== 3'b000) begin
         n_bad++;
         $display("FAIL w3_12345: got bcd=%h of=%b lat=%0d lz=%b want 345 1 16 000",
                  b[11:0], o, lat, z[2:0]);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      valid8 = 1'b0; data8 = '0;
      va = 1'b0; da = '0;
      vb = 1'b0; db = '0;
      @(negedge clk);
      @(negedge clk);
      test_reset;
      rst_n = 1'b1;
      test_zero;
      test_spot;
      test_sweep;
      test_back_to_back;
      test_reset_mid;
      test_wide;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
